enemy_pacer: RTL and testbench
==============================

# enemy_pacer

Timing and health stage that feeds the enemy state machine. It produces the movement tick `enable` (rate set by `speed`) and the pseudo-random direction bit `go`. It owns the enemy `health` register and applies player hits to it. It also counts enemy moves and, after 4 moves (calm) or 2 moves (aggressive), runs a wind-up then strike sequence that the VGA and player logic consume. Its inputs `speed`, `attack` and `dead` come back from the enemy state machine's outputs.

## Interface
Parameters:
- `CALM_DIV`, 25000000: clocks per movement tick when `speed`=0 (min 4).
- `FAST_DIV`, 12500000: clocks per movement tick when `speed`=1 (min 2, must be < `CALM_DIV`).
- `WINDUP_CYCLES`, 25000000: clocks the wind-up lasts (min 1).
- `HEALTH_INIT`, 4'd10: health after reset (1..15).
- `LFSR_SEED`, 8'hA5: LFSR reset value (nonzero).

Ports:
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `speed` in 1: 0 = calm rate, 1 = fast rate.
- `attack` in 1: 0 = strike every 4 moves, 1 = every 2 moves.
- `dead` in 1: enemy-dead indication from the state machine.
- `hit` in 1: one-cycle pulse when the player punch lands.
- `enable` out 1: one-cycle movement tick.
- `go` out 1: direction select, equals LFSR bit 0.
- `health` out 4: current enemy health.
- `windup` out 1: high for the whole wind-up.
- `strike` out 1: one-cycle enemy punch pulse.

## Operation
- FSM states and transitions:
  - RUN → WINDUP: on the clock after the `enable` pulse that brings `move_cnt` to its threshold.
  - WINDUP → STRIKE: after exactly `WINDUP_CYCLES` clocks in WINDUP.
  - STRIKE → RUN: after 1 clock.
  - Any state → DEAD: when `dead`=1, or on the edge that writes `health`=0. DEAD takes priority over every other transition.
  - DEAD → RUN: only on reset.
- Divider (RUN only):
  - Width `$clog2(CALM_DIV)`. Limit is `CALM_DIV-1` if `speed`=0, else `FAST_DIV-1`, evaluated every cycle.
  - When count ≥ limit: `enable`=1 this cycle and the counter goes to 0. Otherwise it increments.
  - A `speed` change mid-count applies immediately. If the count already exceeds the new limit, it fires the next cycle.
  - Outside RUN the divider is held at 0 and `enable`=0.
- Move counter (`move_cnt`, 2 bits):
  - Increments on each `enable` pulse.
  - Threshold is 4 if `attack`=0, 2 if `attack`=1, sampled on the pulse cycle. The count of 4 wraps 3→0, which is detected as the 4th pulse.
  - Cleared on entry to WINDUP.
  - If `attack` rises when `move_cnt` ≥ 2, the next pulse triggers WINDUP.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It shifts every clock in every state except DEAD, where it holds.
- Health:
  - `hit` in RUN or STRIKE subtracts 1. `hit` in WINDUP (counter-punch) subtracts 2.
  - Saturates at 0, never wraps.
  - Ignored in DEAD.
  - `hit` on the same edge as a state transition is judged by the current (pre-edge) state.
- DEAD: `enable`, `windup` and `strike` are 0, and `health` holds.

## Timing
- Reset values: state RUN, divider 0, `move_cnt` 0, LFSR `LFSR_SEED`.
- Reset outputs: `enable` 0, `go` `LFSR_SEED[0]` (1 for the default), `health` `HEALTH_INIT`, `windup` 0, `strike` 0.
- All outputs are registered or decoded from registered state. There is no combinational path from input to output except that `enable` depends on the current `speed` through the limit compare.
- `health` reflects a `hit` one clock after the pulse.
- `windup` rises 1 clock after the triggering `enable` and stays high `WINDUP_CYCLES` clocks. `strike` follows on the next clock for 1 clock. The divider restarts from 0 on the clock after `strike`.
- Reset asserted mid-WINDUP or mid-STRIKE: returns to RUN on the next edge with all reset values. No `strike` is emitted.
- `dead` or `health`=0 during WINDUP aborts it. `strike` is never emitted.

## Test plan
Bench parameters: `CALM_DIV`=8, `FAST_DIV`=4, `WINDUP_CYCLES`=3, `HEALTH_INIT`=10.
- Reset, `speed`=0, `attack`=0 → `enable` pulses every 8 clocks. After the 4th pulse, `windup`=1 for 3 clocks, then `strike`=1 for 1 clock, then pulses resume 8 clocks later.
- `speed`=1, `attack`=1 → `enable` every 4 clocks, wind-up after every 2nd pulse. Switching `speed` 0→1 at divider count 6 → `enable` on the next clock.
- 3 `hit` pulses in RUN and 1 during WINDUP → `health` goes 10→9→8→7→5, each change 1 clock after its pulse.
- 10 `hit` pulses in RUN → `health` reaches 0 and the FSM enters DEAD on the same edge. `enable`, `windup` and `strike` stay 0 and `health` stays 0 under further hits.
- `reset_n`=0 for 1 clock in the middle of WINDUP → next cycle all outputs are at reset values and no `strike` pulse occurs.
- `go` sequence over 16 clocks after reset matches a reference model of the 8-bit LFSR seeded with 8'hA5. `dead`=1 for one cycle → DEAD, and `go` freezes.

Source files
------------

// File: rtl/enemy_pacer.sv
// enemy_pacer: movement tick divider, direction LFSR, enemy health register
// and the move-count driven wind-up / strike sequencer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_RUN    | divider running, enable ticks counted toward a wind-up
// S_WINDUP | enemy winding up a punch for WINDUP_CYCLES clocks
// S_STRIKE | one-cycle enemy punch
// S_DEAD   | enemy defeated; everything frozen until reset
module enemy_pacer #(
  parameter int         CALM_DIV      = 25000000,
  parameter int         FAST_DIV      = 12500000,
  parameter int         WINDUP_CYCLES = 25000000,
  parameter logic [3:0] HEALTH_INIT   = 4'd10,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       speed,
  input  logic       attack,
  input  logic       dead,
  input  logic       hit,
  output logic       enable,
  output logic       go,
  output logic [3:0] health,
  output logic       windup,
  output logic       strike
);

  localparam int DIV_W = $clog2(CALM_DIV);
  localparam int WU_W  = $clog2(WINDUP_CYCLES + 1);
  localparam logic [DIV_W-1:0] CALM_LIM = DIV_W'(CALM_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LIM = DIV_W'(FAST_DIV - 1);
  localparam logic [WU_W-1:0]  WU_LOAD  = WU_W'(WINDUP_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_WINDUP, S_STRIKE, S_DEAD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_limit;
  logic [1:0]       r_move;
  logic [WU_W-1:0]  r_wu_cnt;
  logic [7:0]       r_lfsr;
  logic [3:0]       r_health;
  logic [3:0]       w_health_nxt;
  logic             w_trigger;
  logic             w_lfsr_fb;

  // The limit follows speed combinationally so a rate change takes effect at once.
  assign w_limit   = speed ? FAST_LIM : CALM_LIM;
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign go        = r_lfsr[0];
  assign health    = r_health;

  // Hit damage judged by the pre-edge state; a counter-punch during wind-up costs 2.
  always_comb begin
    w_health_nxt = r_health;
    if (hit) begin
      case (r_state)
        S_RUN, S_STRIKE: w_health_nxt = (r_health == 4'd0) ? 4'd0 : r_health - 4'd1;
        S_WINDUP:        w_health_nxt = (r_health < 4'd2)  ? 4'd0 : r_health - 4'd2;
        default:         w_health_nxt = r_health;
      endcase
    end
  end

  // Next-state and output decode; DEAD overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    enable      = 1'b0;
    windup      = 1'b0;
    strike      = 1'b0;
    w_trigger   = 1'b0;
    case (r_state)
      S_RUN: begin
        enable = (r_div >= w_limit);
        // Calm: 4th tick is the 3->0 wrap. Aggressive: any tick leaving move_cnt >= 2.
        w_trigger = enable && (attack ? (r_move != 2'd0) : (r_move == 2'd3));
        if (w_trigger) w_state_nxt = S_WINDUP;
      end
      S_WINDUP: begin
        windup = 1'b1;
        if (r_wu_cnt == '0) w_state_nxt = S_STRIKE;
      end
      S_STRIKE: begin
        strike      = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_DEAD;
    endcase
    if (r_state != S_DEAD && (dead || w_health_nxt == 4'd0)) w_state_nxt = S_DEAD;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  // Movement divider: free-running in RUN, parked at zero elsewhere.
  always_ff @(posedge clock) begin
    if (!reset_n)                        r_div <= '0;
    else if (r_state != S_RUN || enable) r_div <= '0;
    else                                 r_div <= r_div + 1'b1;
  end

  // Move counter, cleared on wind-up entry.
  always_ff @(posedge clock) begin
    if (!reset_n)       r_move <= 2'd0;
    else if (w_trigger) r_move <= 2'd0;
    else if (enable)    r_move <= r_move + 2'd1;
  end

  // Wind-up length as a down-counter; terminal count zero ends the wind-up.
  always_ff @(posedge clock) begin
    if (!reset_n)                                 r_wu_cnt <= '0;
    else if (w_trigger)                           r_wu_cnt <= WU_LOAD;
    else if (r_state == S_WINDUP && r_wu_cnt != '0) r_wu_cnt <= r_wu_cnt - 1'b1;
  end

  // Direction LFSR, frozen once the enemy is dead.
  always_ff @(posedge clock) begin
    if (!reset_n)              r_lfsr <= LFSR_SEED;
    else if (r_state != S_DEAD) r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  // Health register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_health <= HEALTH_INIT;
    else          r_health <= w_health_nxt;
  end

endmodule

// File: tb/tb_enemy_pacer.sv
// Bench for enemy_pacer: per-cycle vector table with a scoreboard queue,
// plus a hand-written LFSR / dead-freeze sequence.
module tb_enemy_pacer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       speed = 1'b0;
  logic       attack = 1'b0;
  logic       dead = 1'b0;
  logic       hit = 1'b0;
  logic       enable, go, windup, strike;
  logic [3:0] health;

  enemy_pacer #(
    .CALM_DIV(8), .FAST_DIV(4), .WINDUP_CYCLES(3),
    .HEALTH_INIT(4'd10), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .speed(speed), .attack(attack),
    .dead(dead), .hit(hit), .enable(enable), .go(go), .health(health),
    .windup(windup), .strike(strike)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    int         cyc;
    logic       rst_n, spd, att, dd, ht, chk, en, wu, st;
    logic [3:0] hl;
  } vec_t;

  typedef struct {
    string      tag;
    int         cyc;
    logic       chk, en, wu, st;
    logic [3:0] hl;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  logic go_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic add(input string tag, input int cyc, input logic r, input logic s,
                     input logic a, input logic d, input logic h, input logic c,
                     input logic e, input logic w, input logic st, input logic [3:0] hl);
    vec_t v;
    v.tag = tag; v.cyc = cyc; v.rst_n = r; v.spd = s; v.att = a; v.dd = d; v.ht = h;
    v.chk = c; v.en = e; v.wu = w; v.st = st; v.hl = hl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int cyc, input logic [3:0] act,
                       input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic d,
                       input logic h);
    @(posedge clock);
    #1;
    reset_n = r; speed = s; attack = a; dead = d; hit = h;
  endtask

  initial begin
    logic [7:0] m;
    logic       g;
    exp_t       e;

    // Calm pacing: ticks every 8, wind-up after 4th, resume 8 clocks after strike.
    add("rstA", -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 43; c++)
      add("calm", c, 1, 0, 0, 0, 0, 1, (c inside {7, 15, 23, 31, 43}),
          (c >= 32 && c <= 34), (c == 35), 4'd10);

    // Fast + aggressive: ticks every 4, wind-up after every 2nd tick.
    add("rstB", -1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 23; c++)
      add("fast", c, 1, 1, 1, 0, 0, 1, (c inside {3, 7, 15, 19}),
          ((c >= 8 && c <= 10) || (c >= 20 && c <= 22)), (c == 11 || c == 23), 4'd10);

    // Speed 0->1 while divider sits at 6: fires immediately, then every 4.
    add("rstC", -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 10; c++)
      add("spdsw", c, 1, (c >= 6), 0, 0, 0, 1, (c == 6 || c == 10), 0, 0, 4'd10);

    // Three hits in RUN, one counter-punch during wind-up.
    add("rstD", -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 36; c++)
      add("hits", c, 1, 0, 0, 0, (c inside {1, 3, 5, 33}), 1, (c inside {7, 15, 23, 31}),
          (c >= 32 && c <= 34), (c == 35),
          (c < 2) ? 4'd10 : (c < 4) ? 4'd9 : (c < 6) ? 4'd8 : (c < 34) ? 4'd7 : 4'd5);

    // Ten hits kill the enemy; further hits ignored, no ticks in DEAD.
    add("rstE", -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 20; c++)
      add("kill", c, 1, 0, 0, 0, (c <= 13), 1, (c == 7), 0, 0,
          (c <= 10) ? 4'(10 - c) : 4'd0);

    // Reset mid-wind-up: no strike, everything back to reset values.
    add("rstF", -1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 18; c++)
      add("wurst", c, (c != 9), 1, 1, 0, (c == 5), 1, (c inside {3, 7, 13, 17}),
          (c == 8 || c == 9 || c == 18), 0, (c >= 6 && c <= 9) ? 4'd9 : 4'd10);

    // dead during wind-up aborts it; hit in DEAD ignored.
    add("rstG", -1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'd10);
    for (int c = 0; c <= 13; c++)
      add("wudead", c, 1, 1, 1, (c == 9), (c == 12), 1, (c inside {3, 7}),
          (c == 8 || c == 9), 0, 4'd10);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].spd, vecs[i].att, vecs[i].dd, vecs[i].ht);
      e.tag = vecs[i].tag; e.cyc = vecs[i].cyc; e.chk = vecs[i].chk;
      e.en = vecs[i].en; e.wu = vecs[i].wu; e.st = vecs[i].st; e.hl = vecs[i].hl;
      exp_q.push_back(e);
      @(negedge clock);
      e = exp_q.pop_front();
      if (e.chk) begin
        check({e.tag, ".enable"}, e.cyc, {3'b0, enable}, {3'b0, e.en});
        check({e.tag, ".windup"}, e.cyc, {3'b0, windup}, {3'b0, e.wu});
        check({e.tag, ".strike"}, e.cyc, {3'b0, strike}, {3'b0, e.st});
        check({e.tag, ".health"}, e.cyc, health, e.hl);
      end
    end

    // LFSR direction sequence against a reference model, then freeze on dead.
    drive(0, 0, 0, 0, 0);
    m = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 0, 0, 0);
      go_q.push_back(m[0]);
      @(negedge clock);
      g = go_q.pop_front();
      check("go.seq", k, {3'b0, go}, {3'b0, g});
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
    drive(1, 0, 0, 1, 0);
    go_q.push_back(m[0]);
    @(negedge clock);
    g = go_q.pop_front();
    check("go.deadcyc", 16, {3'b0, go}, {3'b0, g});
    m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    for (int k = 17; k < 23; k++) begin
      drive(1, 1, 0, 0, 0);
      go_q.push_back(m[0]);
      @(negedge clock);
      g = go_q.pop_front();
      check("go.frozen", k, {3'b0, go}, {3'b0, g});
      check("dead.enable", k, {3'b0, enable}, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
